// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the halfword PC, drives dual-bank ROM addressing and output-mux
// selects, and steps the PC by the number of instructions the decoder consumed.
module fetch_sequencer #(
    parameter int unsigned PC_W     = 15,
    parameter int unsigned PROG_LEN = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic [1:0]      issue_cnt,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt_req,
    output logic [PC_W-2:0] rom_addr,
    output logic            pc_1,
    output logic            sel_mem_1,
    output logic [1:0]      sel_mem_0,
    output logic [PC_W-1:0] pc_out,
    output logic            valid_0,
    output logic            valid_1,
    output logic            fault
);

    localparam int unsigned EXT_W = PC_W + 1;
    localparam logic [EXT_W-1:0] LEN_X = EXT_W'(PROG_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;

    // Range arithmetic is done one bit wider so PC near the top never aliases.
    logic [EXT_W-1:0] pc_x;
    logic             v0, v1;
    logic [1:0]       issue_lim, avail, eff;
    logic             redir_ok, consumed_all;

    assign pc_x         = {1'b0, pc_q};
    assign v0           = (state_q == S_RUN) && (pc_x < LEN_X);
    assign v1           = v0 && ((pc_x + EXT_W'(1)) < LEN_X);
    assign issue_lim    = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
    assign avail        = {1'b0, v0} + {1'b0, v1};
    assign eff          = (issue_lim < avail) ? issue_lim : avail;
    assign redir_ok     = {1'b0, redirect_pc} < LEN_X;
    assign consumed_all = (pc_x + EXT_W'(eff)) >= LEN_X;

    // Next-state: redirect > halt_req > stall > issue while fetching.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN, S_FLUSH: begin
                if (redirect) begin
                    if (redir_ok) begin
                        pc_d    = redirect_pc;
                        state_d = S_FLUSH;
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end
                end else if (halt_req) begin
                    state_d = S_HALT;
                end else if (state_q == S_FLUSH) begin
                    state_d = S_RUN;
                end else if (!stall) begin
                    pc_d = pc_q + PC_W'(eff);
                    if (consumed_all) state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_W'(RESET_PC);
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Odd PC takes IR_0 from bank1 and IR_1 from bank0 of the next row.
    assign rom_addr  = pc_q[PC_W-1:1];
    assign pc_1      = pc_q[0];
    assign sel_mem_1 = ~pc_q[0];
    assign sel_mem_0 = pc_q[0] ? 2'd2 : 2'd0;
    assign pc_out    = pc_q;
    assign valid_0   = v0;
    assign valid_1   = v1;
    assign fault     = fault_q;

    issue_cnt_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_RUN) |-> (issue_cnt != 2'd3));

endmodule
